// File: rtl/mgmt_core_timer_wrapper_pkg.sv
// Shared CSR offsets, widths and firmware check codes for the management-core timer wrapper.
package mgmt_core_pkg;

  localparam int unsigned LA_W = 38;

  localparam logic [31:0] ADDR_LOAD    = 32'h0000_0000;
  localparam logic [31:0] ADDR_RELOAD  = 32'h0000_0004;
  localparam logic [31:0] ADDR_EN      = 32'h0000_0008;
  localparam logic [31:0] ADDR_UPDATE  = 32'h0000_000C;
  localparam logic [31:0] ADDR_LATCH   = 32'h0000_0010;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0014;
  localparam logic [31:0] ADDR_PENDING = 32'h0000_0018;
  localparam logic [31:0] ADDR_ENABLE  = 32'h0000_001C;
  localparam logic [31:0] ADDR_LA_LO   = 32'h0000_0020;
  localparam logic [31:0] ADDR_LA_HI   = 32'h0000_0024;
  localparam logic [31:0] ADDR_GPIO    = 32'h0000_0028;

  localparam logic [5:0] CHK_START = 6'h0a;
  localparam logic [5:0] CHK_TIMER = 6'h01;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mgmt_core_timer_wrapper_if.sv
// Wishbone slave bundle between the management CPU data bus and the timer wrapper.
interface mgmt_core_timer_wrapper_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [3:0]        wb_sel_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/mgmt_core_timer_wrapper_timer.sv
// Down-counting timer with load/reload, snapshot latch and a zero-crossing event.
module mgmt_timer
  import mgmt_core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_i,
  input  logic [31:0] off_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] load_o,
  output logic [31:0] reload_o,
  output logic        en_o,
  output logic [31:0] value_o,
  output logic [31:0] latch_o,
  output logic        pending_o,
  output logic        enable_o,
  output logic        irq_o
);

  logic [31:0] load_q, load_d;
  logic [31:0] reload_q, reload_d;
  logic        en_q, en_d;
  logic [31:0] value_q, value_d;
  logic [31:0] latch_q, latch_d;
  logic        pending_q, pending_d;
  logic        enable_q, enable_d;
  logic        clr_s;
  logic        set_s;

  // CSR writes: configuration, snapshot request and pending clear
  always_comb begin
    load_d   = load_q;
    reload_d = reload_q;
    en_d     = en_q;
    latch_d  = latch_q;
    enable_d = enable_q;
    clr_s    = 1'b0;
    if (wr_i) begin
      case (off_i)
        ADDR_LOAD:   load_d   = byte_merge(load_q, dat_i, sel_i);
        ADDR_RELOAD: reload_d = byte_merge(reload_q, dat_i, sel_i);
        ADDR_EN: begin
          if (sel_i[0]) begin
            en_d = dat_i[0];
          end else begin
            en_d = en_q;
          end
        end
        // snapshot takes the counter as it stands before this edge's update
        ADDR_UPDATE: begin
          if (sel_i[0] && dat_i[0]) begin
            latch_d = value_q;
          end else begin
            latch_d = latch_q;
          end
        end
        ADDR_PENDING: clr_s = sel_i[0] & dat_i[0];
        ADDR_ENABLE: begin
          if (sel_i[0]) begin
            enable_d = dat_i[0];
          end else begin
            enable_d = enable_q;
          end
        end
        default: clr_s = 1'b0;
      endcase
    end else begin
      clr_s = 1'b0;
    end
  end

  // Counter step and zero-crossing event; a coinciding set beats the clear
  always_comb begin
    value_d   = value_q;
    pending_d = pending_q;
    set_s     = en_q & (value_q == 32'd1);
    if (!en_q) begin
      value_d = load_q;
    end else if (value_q != 32'd0) begin
      value_d = value_q - 32'd1;
    end else begin
      value_d = reload_q;
    end
    if (set_s) begin
      pending_d = 1'b1;
    end else if (clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Timer state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      load_q    <= 32'd0;
      reload_q  <= 32'd0;
      en_q      <= 1'b0;
      value_q   <= 32'd0;
      latch_q   <= 32'd0;
      pending_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      load_q    <= load_d;
      reload_q  <= reload_d;
      en_q      <= en_d;
      value_q   <= value_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
    end
  end

  assign load_o    = load_q;
  assign reload_o  = reload_q;
  assign en_o      = en_q;
  assign value_o   = value_q;
  assign latch_o   = latch_q;
  assign pending_o = pending_q;
  assign enable_o  = enable_q;
  assign irq_o     = pending_q & enable_q;

endmodule

// File: rtl/mgmt_core_timer_wrapper.sv
// Management-core CSR wrapper: Wishbone slave decode, timer, logic-analyzer and GPIO registers.
module mgmt_core_timer_wrapper #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LA_W   = mgmt_core_pkg::LA_W
) (
  input  logic                       core_clk,
  input  logic                       core_rstn,
  mgmt_core_timer_wrapper_if.slave   wb,
  output logic [LA_W-1:0]            la_output,
  output logic                       gpio_out_pad,
  output logic                       irq
);
  import mgmt_core_pkg::*;

  localparam int unsigned LA_HI_W = LA_W - 32;

  logic [ADDR_W-1:0]  adr_s;
  logic [31:0]        off_s;
  logic               req_s;
  logic               wr_s;
  logic [31:0]        rdata_s;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        la_lo_q, la_lo_d;
  logic [LA_HI_W-1:0] la_hi_q, la_hi_d;
  logic               gpio_q, gpio_d;

  logic [31:0] t_load_s;
  logic [31:0] t_reload_s;
  logic        t_en_s;
  logic [31:0] t_value_s;
  logic [31:0] t_latch_s;
  logic        t_pending_s;
  logic        t_enable_s;
  logic        t_irq_s;

  assign adr_s = wb.wb_adr_i;

  // Request qualification; the pending ack blocks a second request in the same cycle
  always_comb begin
    off_s = 32'(adr_s) & 32'hFFFF_FFFC;
    req_s = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    wr_s  = req_s & wb.wb_we_i;
  end

  mgmt_timer u_timer (
    .clk       (core_clk),
    .rstn      (core_rstn),
    .wr_i      (wr_s),
    .off_i     (off_s),
    .dat_i     (wb.wb_dat_i),
    .sel_i     (wb.wb_sel_i),
    .load_o    (t_load_s),
    .reload_o  (t_reload_s),
    .en_o      (t_en_s),
    .value_o   (t_value_s),
    .latch_o   (t_latch_s),
    .pending_o (t_pending_s),
    .enable_o  (t_enable_s),
    .irq_o     (t_irq_s)
  );

  // Logic-analyzer and GPIO register writes
  always_comb begin
    la_lo_d = la_lo_q;
    la_hi_d = la_hi_q;
    gpio_d  = gpio_q;
    if (wr_s) begin
      case (off_s)
        ADDR_LA_LO: la_lo_d = byte_merge(la_lo_q, wb.wb_dat_i, wb.wb_sel_i);
        ADDR_LA_HI: begin
          if (wb.wb_sel_i[0]) begin
            la_hi_d = wb.wb_dat_i[LA_HI_W-1:0];
          end else begin
            la_hi_d = la_hi_q;
          end
        end
        ADDR_GPIO: begin
          if (wb.wb_sel_i[0]) begin
            gpio_d = wb.wb_dat_i[0];
          end else begin
            gpio_d = gpio_q;
          end
        end
        default: gpio_d = gpio_q;
      endcase
    end else begin
      gpio_d = gpio_q;
    end
  end

  // Read mux; write-only and unmapped offsets return zero
  always_comb begin
    case (off_s)
      ADDR_LOAD:    rdata_s = t_load_s;
      ADDR_RELOAD:  rdata_s = t_reload_s;
      ADDR_EN:      rdata_s = {31'd0, t_en_s};
      ADDR_LATCH:   rdata_s = t_latch_s;
      ADDR_STATUS:  rdata_s = {31'd0, (t_value_s == 32'd0)};
      ADDR_PENDING: rdata_s = {31'd0, t_pending_s};
      ADDR_ENABLE:  rdata_s = {31'd0, t_enable_s};
      ADDR_LA_LO:   rdata_s = la_lo_q;
      ADDR_LA_HI:   rdata_s = 32'(la_hi_q);
      ADDR_GPIO:    rdata_s = {31'd0, gpio_q};
      default:      rdata_s = 32'd0;
    endcase
  end

  // Single-cycle ack with read data held only while ack is high
  always_comb begin
    ack_d = req_s;
    if (req_s && !wb.wb_we_i) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'd0;
    end
  end

  // Bus and output registers with synchronous active-low reset
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      la_lo_q <= 32'd0;
      la_hi_q <= '0;
      gpio_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      la_lo_q <= la_lo_d;
      la_hi_q <= la_hi_d;
      gpio_q  <= gpio_d;
    end
  end

  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_dat_o  = dat_q;
  assign la_output    = {la_hi_q, la_lo_q};
  assign gpio_out_pad = gpio_q;
  assign irq          = t_irq_s;

endmodule

// File: tb/tb_mgmt_core_timer_wrapper.sv
// Directed and randomized bench for mgmt_core_timer_wrapper against an arithmetic timer model.
module tb_mgmt_core_timer_wrapper;
  import mgmt_core_pkg::*;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;
  logic [37:0] la_output;
  logic        gpio_out_pad;
  logic        irq;

  mgmt_core_timer_wrapper_if #(.ADDR_W(8)) bus ();

  mgmt_core_timer_wrapper #(.ADDR_W(8), .LA_W(38)) dut (
    .core_clk     (core_clk),
    .core_rstn    (core_rstn),
    .wb           (bus),
    .la_output    (la_output),
    .gpio_out_pad (gpio_out_pad),
    .irq          (irq)
  );

  always #5 core_clk = ~core_clk;

  int cyc_cnt = 0;
  always @(posedge core_clk) cyc_cnt <= cyc_cnt + 1;

  int total = 0;
  int bad = 0;
  int last_commit = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge core_clk);
      @(negedge core_clk);
    end
  endtask

  // one request, one ack cycle, one idle cycle; records the commit edge index
  task automatic xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    @(posedge core_clk);
    @(negedge core_clk);
    last_commit = cyc_cnt;
    chk("ack", {63'd0, bus.wb_ack_o}, 64'd1);
    rd = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    xfer(1'b1, adr, dat, sel, dummy);
  endtask

  task automatic rd(input logic [7:0] adr, output logic [31:0] data);
    xfer(1'b0, adr, 32'd0, 4'hF, data);
  endtask

  // counter value k edges after the enabling edge (k = 0 -> load)
  function automatic logic [31:0] f_val(input logic [31:0] l, input logic [31:0] r, input int k);
    longint kk;
    kk = longint'(k);
    if (kk <= longint'(l)) return l - 32'(k);
    if (r == 32'd0) return 32'd0;
    return r - 32'((kk - longint'(l) - 64'sd1) % (longint'(r) + 64'sd1));
  endfunction

  // pending after edge k, given a clear at edge kc (0 = no clear since enable)
  function automatic logic pend_exp(input logic [31:0] l, input logic [31:0] r, input int k, input int kc);
    for (int j = (kc < 1) ? 1 : kc; j <= k; j++) begin
      if (f_val(l, r, j - 1) == 32'd1) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic [31:0] rdat;
    logic [31:0] m_reg [6];
    logic [31:0] fmask [6];
    logic [7:0]  radr [6];
    logic [31:0] bm;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] fw_l;
    int          idx;
    int          e0;
    int          kc;
    int          k;
    longint      diff;

    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 8'h00;
    bus.wb_dat_i = 32'd0;

    // reset
    core_rstn = 1'b0;
    repeat (5) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_la", {26'd0, la_output}, 64'd0);
    chk("rst_gpio", {63'd0, gpio_out_pad}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    chk("rst_dat", {32'd0, bus.wb_dat_o}, 64'd0);
    core_rstn = 1'b1;
    idle(1);
    rd(8'h10, rdat);
    chk("rst_latch", {32'd0, rdat}, 64'd0);

    // held strobe: ack on alternate cycles
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 8'h08;
    for (int i = 1; i <= 6; i++) begin
      @(posedge core_clk);
      @(negedge core_clk);
      chk("ack_alt", {63'd0, bus.wb_ack_o}, {63'd0, (i % 2 == 1)});
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    idle(1);

    // byte-masked write and unmapped space
    wr(8'h20, 32'd0, 4'hF);
    wr(8'h20, 32'hAABBCCDD, 4'b0101);
    rd(8'h20, rdat);
    chk("sel_rd", {32'd0, rdat}, 64'h00BB00DD);
    chk("sel_la", {32'd0, la_output[31:0]}, 64'h00BB00DD);
    wr(8'h3C, 32'hFFFFFFFF, 4'hF);
    rd(8'h3C, rdat);
    chk("unmapped", {32'd0, rdat}, 64'd0);
    rd(8'h0C, rdat);
    chk("update_rd0", {32'd0, rdat}, 64'd0);
    rd(8'h20, rdat);
    chk("unmapped_nowr", {32'd0, rdat}, 64'h00BB00DD);

    // randomized RW register traffic against a shadow register file
    radr  = '{8'h00, 8'h04, 8'h20, 8'h24, 8'h28, 8'h1C};
    fmask = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000003F, 32'h1, 32'h1};
    m_reg = '{32'd0, 32'd0, 32'h00BB00DD, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(0, 5);
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      bm  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      m_reg[idx] = ((m_reg[idx] & ~bm) | (d & bm)) & fmask[idx];
      wr(radr[idx], d, s);
      rd(radr[idx], rdat);
      chk("rand_rw", {32'd0, rdat}, {32'd0, m_reg[idx]});
    end
    chk("rand_la", {26'd0, la_output}, {26'd0, m_reg[3][5:0], m_reg[2]});
    chk("rand_gpio", {63'd0, gpio_out_pad}, {63'd0, m_reg[4][0]});
    wr(8'h28, 32'd1, 4'hF);
    chk("gpio_set", {63'd0, gpio_out_pad}, 64'd1);

    // firmware flow
    wr(8'h24, {26'd0, CHK_START}, 4'hF);
    chk("fw_start", {58'd0, la_output[37:32]}, {58'd0, CHK_START});
    fw_l = 32'hdcba9876;
    wr(8'h00, fw_l, 4'hF);
    wr(8'h04, 32'd0, 4'hF);
    wr(8'h08, 32'd1, 4'hF);
    e0 = last_commit;
    idle(100);
    wr(8'h0C, 32'd1, 4'hF);
    kc = last_commit - e0;
    rd(8'h10, rdat);
    chk("fw_latch", {32'd0, rdat}, {32'd0, f_val(fw_l, 32'd0, kc - 1)});
    diff = longint'(rdat) - (longint'(fw_l) - 64'sd100);
    chk("fw_range", {63'd0, (rdat < fw_l) && (diff <= 64'sd4) && (diff >= -64'sd4)}, 64'd1);
    wr(8'h20, rdat, 4'hF);
    wr(8'h24, {26'd0, CHK_TIMER}, 4'hF);
    chk("fw_la", {26'd0, la_output}, {26'd0, CHK_TIMER, rdat});
    wr(8'h08, 32'd0, 4'hF);

    // one-shot
    wr(8'h00, 32'd5, 4'hF);
    wr(8'h04, 32'd0, 4'hF);
    wr(8'h18, 32'd1, 4'hF);
    wr(8'h1C, 32'd1, 4'hF);
    chk("os_irq0", {63'd0, irq}, 64'd0);
    wr(8'h08, 32'd1, 4'hF);
    e0 = last_commit;
    idle(10);
    k = cyc_cnt - e0;
    chk("os_val", {32'd0, dut.u_timer.value_o}, {32'd0, f_val(32'd5, 32'd0, k)});
    chk("os_irq", {63'd0, irq}, {63'd0, pend_exp(32'd5, 32'd0, k, 0)});
    rd(8'h14, rdat);
    chk("os_status", {32'd0, rdat}, 64'd1);
    idle(3);
    chk("os_stay0", {32'd0, dut.u_timer.value_o}, 64'd0);
    wr(8'h18, 32'd1, 4'hF);
    chk("os_clr", {63'd0, irq}, 64'd0);
    rd(8'h18, rdat);
    chk("os_pend_rd", {32'd0, rdat}, 64'd0);
    wr(8'h08, 32'd0, 4'hF);

    // periodic
    wr(8'h00, 32'd3, 4'hF);
    wr(8'h04, 32'd3, 4'hF);
    wr(8'h18, 32'd1, 4'hF);
    wr(8'h08, 32'd1, 4'hF);
    e0 = last_commit;
    for (int i = 0; i < 8; i++) begin
      k = cyc_cnt - e0;
      chk("per_val", {32'd0, dut.u_timer.value_o}, {32'd0, f_val(32'd3, 32'd3, k)});
      chk("per_irq", {63'd0, irq}, {63'd0, pend_exp(32'd3, 32'd3, k, 0)});
      idle(1);
    end
    for (int i = 0; i < 8 && f_val(32'd3, 32'd3, cyc_cnt - e0) != 32'd1; i++) idle(1);
    wr(8'h18, 32'd1, 4'hF);
    kc = last_commit - e0;
    k  = cyc_cnt - e0;
    chk("per_setwins", {63'd0, irq}, {63'd0, pend_exp(32'd3, 32'd3, k, kc)});
    for (int i = 0; i < 8 && f_val(32'd3, 32'd3, cyc_cnt - e0) != 32'd3; i++) idle(1);
    wr(8'h18, 32'd1, 4'hF);
    kc = last_commit - e0;
    k  = cyc_cnt - e0;
    chk("per_clr", {63'd0, irq}, {63'd0, pend_exp(32'd3, 32'd3, k, kc)});
    wr(8'h08, 32'd0, 4'hF);

    // load write while running, then disable
    wr(8'h00, 32'd20, 4'hF);
    wr(8'h04, 32'd0, 4'hF);
    wr(8'h08, 32'd1, 4'hF);
    e0 = last_commit;
    idle(3);
    wr(8'h00, 32'd7, 4'hF);
    for (int i = 0; i < 4; i++) begin
      k = cyc_cnt - e0;
      chk("race_val", {32'd0, dut.u_timer.value_o}, {32'd0, f_val(32'd20, 32'd0, k)});
      idle(1);
    end
    wr(8'h08, 32'd0, 4'hF);
    chk("race_dis", {32'd0, dut.u_timer.value_o}, 64'd7);
    idle(1);
    chk("race_hold", {32'd0, dut.u_timer.value_o}, 64'd7);

    // reset mid-count
    wr(8'h00, 32'd50, 4'hF);
    wr(8'h1C, 32'd1, 4'hF);
    wr(8'h08, 32'd1, 4'hF);
    idle(3);
    core_rstn = 1'b0;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("mrst_val", {32'd0, dut.u_timer.value_o}, 64'd0);
    chk("mrst_la", {26'd0, la_output}, 64'd0);
    chk("mrst_gpio", {63'd0, gpio_out_pad}, 64'd0);
    chk("mrst_irq", {63'd0, irq}, 64'd0);
    core_rstn = 1'b1;
    idle(1);
    rd(8'h08, rdat);
    chk("mrst_en", {32'd0, rdat}, 64'd0);
    rd(8'h00, rdat);
    chk("mrst_load", {32'd0, rdat}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mgmt_core_timer_wrapper.md
Name: mgmt_core_timer_wrapper

Overview:
- Reduced management-core wrapper: a Wishbone-slave CSR block with a 32-bit down-counting timer (LiteX timer0 semantics), a 38-bit logic-analyzer output register and a single GPIO output.
- Firmware on the management CPU programs the timer, samples its value and reports progress and results through la_output (bits [37:32] = check code, bits [31:0] = data).
- Sits between the CPU data bus and the pads / LA pins.

Parameters:
- ADDR_W, 8, byte-address width of the CSR window.
- LA_W, 38, logic-analyzer output width.

Ports:
- core_clk  in  1  sole clock; all logic on rising edge.
- core_rstn  in  1  reset; synchronous and active-low, sampled on core_clk.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  4  byte enables for writes.
- wb_adr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- la_output  out  LA_W  logic-analyzer outputs.
- gpio_out_pad  out  1  management GPIO output.
- irq  out  1  timer interrupt, level.

Behaviour:
- Reset: every register and output is 0, including value, load, reload, en, pending, enable, LA, GPIO, wb_ack_o, wb_dat_o and irq.
- Bus handshake:
  - A request is cyc & stb & !wb_ack_o. It is acked exactly one cycle later with a single-cycle pulse, so a back-to-back request is acked every second cycle.
  - Writes commit on the request cycle, byte-masked by wb_sel_i.
  - Read data is registered and valid while ack is high.
  - Unmapped addresses read 0 and writes to them are ignored. Unused register bits read 0.
- CSR map (byte offsets):
  - 0x00 load, RW, 32 bits.
  - 0x04 reload, RW, 32 bits.
  - 0x08 en, RW, bit 0.
  - 0x0C update_value, WO: a write with bit 0 = 1 snapshots value into value_latch; reads return 0.
  - 0x10 value_latch, RO.
  - 0x14 ev_status, RO: bit 0 = (value == 0).
  - 0x18 ev_pending, write-1-to-clear, bit 0.
  - 0x1C ev_enable, RW, bit 0.
  - 0x20 la_lo, RW, 32 bits, drives la_output[31:0].
  - 0x24 la_hi, RW, bits [5:0], drives la_output[37:32].
  - 0x28 gpio, RW, bit 0, drives gpio_out_pad.
- Counter, per cycle:
  - en = 0: value <= load.
  - en = 1 and value != 0: value <= value - 1.
  - en = 1 and value == 0: value <= reload.
  - reload = 0 makes the timer one-shot (it stays at 0). Wrap-around is never modular; zero always reloads.
- Event:
  - ev_pending sets in the cycle where en = 1 and value == 1, i.e. the next value is 0.
  - When set and clear coincide in the same cycle, set wins.
  - irq = ev_pending & ev_enable, combinational from registers.
- Writes to load or reload while enabled do not disturb the running value. They take effect only at the next zero crossing or on disable.
- Snapshot captures the pre-update counter of the write cycle.
- Reset asserted mid-count returns everything to 0 on the next clock edge.

Decomposition:
- Package mgmt_core_pkg holds the CSR offset localparams (ADDR_LOAD ... ADDR_GPIO), LA_W, and the check-code constants (CHK_START = 6'h0a, CHK_TIMER = 6'h01).
- One sub-module, mgmt_timer: load, reload, en, value, snapshot and event. The wrapper keeps bus decode, read mux, LA and GPIO.

Test Plan:
- Reset: hold core_rstn = 0 for 5 cycles with the bus idle -> la_output = 0, gpio_out_pad = 0, irq = 0, and a read of 0x10 returns 0.
- Firmware flow:
  - Write la_hi = 0x0a -> la_output[37:32] = 6'h0a.
  - Load 0xdcba9876, reload 0, en = 1, wait 100 cycles, write update_value, read 0x10 -> result < 0xdcba9876 and within ±4 of 0xdcba9876 - 100 after bus latency.
  - Write it to la_lo and write la_hi = 0x01 -> la_output[31:0] equals the read value.
- Zero/one-shot: load 5, reload 0, ev_enable 1, en 1 -> pending and irq rise when value hits 0, value stays 0, ev_status = 1. Writing 1 to 0x18 clears irq.
- Periodic: load 3, reload 3, en 1 -> value sequence 3,2,1,0,3,2,1,0, and pending sets once per period.
- Bus rules:
  - Hold stb high for 6 cycles -> ack pulses on alternate cycles.
  - Write 0xAABBCCDD to la_lo with sel = 4'b0101 over 0 -> la_lo = 0x00BB00DD.
  - Read 0x3C -> 0.
- Disable/reload race: with en 1 mid-count, write load = 7 -> count continues undisturbed. Then en 0 -> value = 7 next cycle.
